stack_port: RTL and testbench

STACK_PORT -- requirements
Module: stack_port

---
 rtl/stack_port_if.sv | 31 +++
 rtl/stack_port.sv | 131 +++++++++++++
 tb/tb_stack_port.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_port_if.sv
// Signal bundle between the control unit, the SP register block, data memory and
// the stack port: command handshake, SP mux control, memory strobes and results.
interface stack_port_if;
    logic        cmdValid;
    logic        cmdPush;
    logic [15:0] cmdData;
    logic        cmdReady;
    logic [15:0] spCur;
    logic [2:0]  spSrc;
    logic        spWrite;
    logic [15:0] memAddr;
    logic        memWrite;
    logic        memRead;
    logic [15:0] memWData;
    logic [15:0] memRData;
    logic        done;
    logic [15:0] popData;
    logic        error;

    modport master (
        output cmdValid, cmdPush, cmdData, spCur, memRData,
        input  cmdReady, spSrc, spWrite, memAddr, memWrite, memRead, memWData,
               done, popData, error
    );

    modport slave (
        input  cmdValid, cmdPush, cmdData, spCur, memRData,
        output cmdReady, spSrc, spWrite, memAddr, memWrite, memRead, memWData,
               done, popData, error
    );
endinterface

// File: rtl/stack_port.sv
// Push/pop sequencer between the control unit, the SP register block and data memory.
// Define STACK_BOUNDS_CHECK_EN to reject overflowing pushes and underflowing pops.
module stack_port #(
    parameter logic [15:0] STACK_LIMIT = 16'hFFFE
) (
    input  logic         clock,
    input  logic         resetN,
    stack_port_if.slave  bus
);

`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [2:0] SP_HOLD = 3'b000;
    localparam logic [2:0] SP_INC  = 3'b001;
    localparam logic [2:0] SP_DEC  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
        S_POPWAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic [15:0] pop_data_q, pop_data_d;
    logic        error_q, error_d;

    logic        reject;
    logic        cmd_ready;
    logic [2:0]  sp_src;
    logic        sp_write;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_wdata;
    logic        done_pulse;

    // Bounds are judged against the pointer seen in the accept cycle; SP cannot move before PUSH/POP.
    assign reject = BOUNDS_EN && (bus.cmdPush ? (bus.spCur > STACK_LIMIT)
                                              : (bus.spCur == 16'h0000));

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        pop_data_d = pop_data_q;
        error_d    = error_q;
        cmd_ready  = 1'b0;
        sp_src     = SP_HOLD;
        sp_write   = 1'b0;
        mem_addr   = 16'h0000;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_wdata  = 16'h0000;
        done_pulse = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmdValid) begin
                    data_d  = bus.cmdData;
                    error_d = reject;
                    if (reject)
                        state_d = S_DONE;
                    else if (bus.cmdPush)
                        state_d = S_PUSH;
                    else
                        state_d = S_POP;
                end
            end
            S_PUSH: begin
                mem_addr  = bus.spCur;
                mem_write = 1'b1;
                mem_wdata = data_q;
                sp_write  = 1'b1;
                sp_src    = SP_INC;
                state_d   = S_DONE;
            end
            S_POP: begin
                // Top of stack sits one word below the pointer; wraps at zero.
                mem_addr = bus.spCur - 16'd2;
                mem_read = 1'b1;
                sp_write = 1'b1;
                sp_src   = SP_DEC;
                state_d  = S_POPWAIT;
            end
            S_POPWAIT: begin
                pop_data_d = bus.memRData;
                state_d    = S_DONE;
            end
            S_DONE: begin
                done_pulse = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            data_q     <= 16'h0000;
            pop_data_q <= 16'h0000;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            pop_data_q <= pop_data_d;
            error_q    <= error_d;
        end
    end

    assign bus.cmdReady = cmd_ready;
    assign bus.spSrc    = sp_src;
    assign bus.spWrite  = sp_write;
    assign bus.memAddr  = mem_addr;
    assign bus.memWrite = mem_write;
    assign bus.memRead  = mem_read;
    assign bus.memWData = mem_wdata;
    assign bus.done     = done_pulse;
    assign bus.popData  = pop_data_q;
    assign bus.error    = done_pulse & error_q;

endmodule

// File: tb/tb_stack_port.sv
// Bench for stack_port: SP block and memory environment, transaction-level model
// checked every cycle, plus directed transactions with literal expectations.
module tb_stack_port;

`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam logic [15:0] LIMIT = 16'h0100;

    logic clock = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    stack_port_if bus ();

    stack_port #(.STACK_LIMIT(LIMIT)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // ---------------- environment: SP register block and data memory ----------------
    logic [15:0] sp_q = 16'h0000;
    logic        sp_set_en = 1'b0;
    logic [15:0] sp_set_val = 16'h0000;
    logic [15:0] env_mem [0:32767];
    bit          env_written [0:32767];
    logic [15:0] rdata_q = 16'h0000;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [15:0] last_wr_addr = 16'h0000;
    logic [15:0] last_wr_data = 16'h0000;
    logic [15:0] last_rd_addr = 16'h0000;

    assign bus.spCur    = sp_q;
    assign bus.memRData = rdata_q;

    always @(posedge clock) begin
        if (sp_set_en)
            sp_q <= sp_set_val;
        else if (bus.spWrite)
            sp_q <= (bus.spSrc == 3'b001) ? sp_q + 16'd2 :
                    (bus.spSrc == 3'b010) ? sp_q - 16'd2 : sp_q;
        if (bus.memWrite) begin
            env_mem[bus.memAddr[15:1]]     <= bus.memWData;
            env_written[bus.memAddr[15:1]] <= 1'b1;
            wr_count     <= wr_count + 1;
            last_wr_addr <= bus.memAddr;
            last_wr_data <= bus.memWData;
        end
        if (bus.memRead) begin
            rdata_q      <= env_written[bus.memAddr[15:1]] ? env_mem[bus.memAddr[15:1]]
                                                            : (bus.memAddr ^ 16'h5A5A);
            rd_count     <= rd_count + 1;
            last_rd_addr <= bus.memAddr;
        end
    end

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        ready;
        logic        sp_wr;
        logic        mem_wr;
        logic        mem_rd;
        logic        done;
        logic        err;
        logic [2:0]  src;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] pop;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] model_mem [logic [15:0]];
    logic [15:0] model_pop = 16'h0000;
    bit          cur_ready = 1'b1;

    function automatic exp_t mk(logic ready, logic [2:0] src, logic sp_wr, logic mem_wr,
                                logic mem_rd, logic [15:0] addr, logic [15:0] wdata,
                                logic done, logic err, logic [15:0] pop);
        exp_t e;
        e.ready = ready; e.src = src; e.sp_wr = sp_wr; e.mem_wr = mem_wr;
        e.mem_rd = mem_rd; e.addr = addr; e.wdata = wdata; e.done = done;
        e.err = err; e.pop = pop;
        return e;
    endfunction

    function automatic logic [15:0] model_read(logic [15:0] a);
        if (model_mem.exists(a))
            return model_mem[a];
        return a ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accept decisions mirror the command rules: a command is taken when the block is idle.
    initial begin
        logic [15:0] s;
        logic [15:0] v;
        forever begin
            @(posedge clock);
            if (!resetN) begin
                expq.delete();
                model_pop = 16'h0000;
            end else if (cur_ready && bus.cmdValid) begin
                acc_cyc = cyc;
                s = bus.spCur;
                if (BOUNDS && (bus.cmdPush ? (s > LIMIT) : (s == 16'h0000))) begin
                    expq.push_back(mk(0, 3'b000, 0, 0, 0, 16'h0, 16'h0, 1, 1, model_pop));
                end else if (bus.cmdPush) begin
                    expq.push_back(mk(0, 3'b001, 1, 1, 0, s, bus.cmdData, 0, 0, model_pop));
                    expq.push_back(mk(0, 3'b000, 0, 0, 0, 16'h0, 16'h0, 1, 0, model_pop));
                    model_mem[s] = bus.cmdData;
                end else begin
                    v = model_read(s - 16'd2);
                    expq.push_back(mk(0, 3'b010, 1, 0, 1, s - 16'd2, 16'h0, 0, 0, model_pop));
                    expq.push_back(mk(0, 3'b000, 0, 0, 0, 16'h0, 16'h0, 0, 0, model_pop));
                    expq.push_back(mk(0, 3'b000, 0, 0, 0, 16'h0, 16'h0, 1, 0, v));
                    model_pop = v;
                end
            end
            cyc = cyc + 1;
        end
    end

    // Every-cycle compare against the model.
    initial begin
        exp_t cur;
        forever begin
            @(negedge clock);
            if (!resetN) begin
                cur_ready = 1'b1;
            end else begin
                cur = (expq.size() > 0) ? expq.pop_front()
                                        : mk(1, 3'b000, 0, 0, 0, 16'h0, 16'h0, 0, 0, model_pop);
                cur_ready = cur.ready;
                check("cmdReady", bus.cmdReady, cur.ready);
                check("spSrc",    bus.spSrc,    cur.src);
                check("spWrite",  bus.spWrite,  cur.sp_wr);
                check("memWrite", bus.memWrite, cur.mem_wr);
                check("memRead",  bus.memRead,  cur.mem_rd);
                check("done",     bus.done,     cur.done);
                check("popData",  bus.popData,  cur.pop);
                if (cur.mem_wr || cur.mem_rd)
                    check("memAddr", bus.memAddr, cur.addr);
                if (cur.mem_wr)
                    check("memWData", bus.memWData, cur.wdata);
                if (cur.done)
                    check("error", bus.error, cur.err);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_sp(input logic [15:0] v);
        @(negedge clock); #2;
        sp_set_en = 1'b1;
        sp_set_val = v;
        @(negedge clock); #2;
        sp_set_en = 1'b0;
    endtask

    task automatic wait_done(output logic err, output int lat);
        bit found = 1'b0;
        err = 1'b0;
        lat = -1;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.done) begin
                found = 1'b1;
                err = bus.error;
                lat = cyc - acc_cyc;
            end else begin
                @(negedge clock); #2;
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done, expected done within 8 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic do_cmd(input logic push, input logic [15:0] data,
                          output logic err, output int lat);
        logic [15:0] sp_at;
        @(negedge clock); #2;
        sp_at = bus.spCur;
        bus.cmdValid = 1'b1;
        bus.cmdPush  = push;
        bus.cmdData  = data;
        @(negedge clock); #2;
        bus.cmdValid = 1'b0;
        wait_done(err, lat);
        $display("txn %s data=%h sp=%h err=%0d latency=%0d popData=%h",
                 push ? "push" : "pop ", data, sp_at, err, lat, bus.popData);
    endtask

    initial begin
        logic err;
        int   lat;
        int   w0;
        int   r0;

        bus.cmdValid = 1'b0;
        bus.cmdPush  = 1'b0;
        bus.cmdData  = 16'h0000;

        repeat (2) @(negedge clock);
        #2;
        check("rst_cmdReady", bus.cmdReady, 1);
        check("rst_done",     bus.done,     0);
        check("rst_popData",  bus.popData,  16'h0000);
        check("rst_memWrite", bus.memWrite, 0);
        resetN = 1'b1;

        // push BEEF at 0x0010
        set_sp(16'h0010);
        w0 = wr_count;
        do_cmd(1'b1, 16'hBEEF, err, lat);
        check("push_latency", lat, 2);
        check("push_error",   err, 0);
        check("push_writes",  wr_count - w0, 1);
        check("push_addr",    last_wr_addr, 16'h0010);
        check("push_data",    last_wr_data, 16'hBEEF);
        check("push_sp",      sp_q, 16'h0012);

        // pop it back from 0x0012
        do_cmd(1'b0, 16'h0000, err, lat);
        check("pop_latency", lat, 3);
        check("pop_error",   err, 0);
        check("pop_addr",    last_rd_addr, 16'h0010);
        check("pop_data",    bus.popData, 16'hBEEF);
        check("pop_sp",      sp_q, 16'h0010);

        // LIFO ordering
        do_cmd(1'b1, 16'h1234, err, lat);
        do_cmd(1'b1, 16'h5678, err, lat);
        check("lifo_popData_held", bus.popData, 16'hBEEF);
        do_cmd(1'b0, 16'h0000, err, lat);
        check("lifo_first", bus.popData, 16'h5678);
        do_cmd(1'b0, 16'h0000, err, lat);
        check("lifo_second", bus.popData, 16'h1234);

        // pop at an empty pointer
        set_sp(16'h0000);
        r0 = rd_count;
        do_cmd(1'b0, 16'h0000, err, lat);
`ifdef STACK_BOUNDS_CHECK_EN
        check("underflow_latency", lat, 1);
        check("underflow_error",   err, 1);
        check("underflow_reads",   rd_count - r0, 0);
        check("underflow_sp",      sp_q, 16'h0000);
        check("underflow_popData", bus.popData, 16'h1234);
`else
        check("wrap_latency", lat, 3);
        check("wrap_error",   err, 0);
        check("wrap_addr",    last_rd_addr, 16'hFFFE);
        check("wrap_data",    bus.popData, 16'hA5A4);
        check("wrap_sp",      sp_q, 16'hFFFE);
`endif

        // push just above and exactly at the limit
        set_sp(16'h0102);
        w0 = wr_count;
        do_cmd(1'b1, 16'hCAFE, err, lat);
`ifdef STACK_BOUNDS_CHECK_EN
        check("overflow_error",   err, 1);
        check("overflow_latency", lat, 1);
        check("overflow_writes",  wr_count - w0, 0);
`else
        check("above_limit_error", err, 0);
        check("above_limit_addr",  last_wr_addr, 16'h0102);
`endif
        set_sp(16'h0100);
        do_cmd(1'b1, 16'h1111, err, lat);
        check("at_limit_error",   err, 0);
        check("at_limit_latency", lat, 2);
        check("at_limit_addr",    last_wr_addr, 16'h0100);

        // cmdValid held high across a push: second accept only after done
        set_sp(16'h0200);
        w0 = wr_count;
        @(negedge clock); #2;
        bus.cmdValid = 1'b1;
        bus.cmdPush  = 1'b1;
        bus.cmdData  = 16'h7777;
        repeat (4) @(negedge clock);
        #2;
        bus.cmdValid = 1'b0;
        wait_done(err, lat);
        $display("txn push-held data=7777 err=%0d latency=%0d writes=%0d", err, lat, wr_count - w0);
        check("held_writes",  wr_count - w0, 2);
        check("held_latency", lat, 2);
        check("held_addr",    last_wr_addr, 16'h0202);
        check("held_sp",      sp_q, 16'h0204);

        // reset asserted while in POP
        r0 = rd_count;
        @(negedge clock); #2;
        bus.cmdValid = 1'b1;
        bus.cmdPush  = 1'b0;
        @(negedge clock); #2;
        bus.cmdValid = 1'b0;
        check("pre_rst_memRead", bus.memRead, 1);
        #1;
        resetN = 1'b0;
        #1;
        check("rst_mid_memRead",  bus.memRead,  0);
        check("rst_mid_spWrite",  bus.spWrite,  0);
        check("rst_mid_memWrite", bus.memWrite, 0);
        check("rst_mid_done",     bus.done,     0);
        check("rst_mid_cmdReady", bus.cmdReady, 1);
        check("rst_mid_popData",  bus.popData,  16'h0000);
        $display("txn pop aborted by reset sp=%h", sp_q);
        repeat (2) @(negedge clock);
        #2;
        check("rst_mid_sp",    sp_q, 16'h0204);
        check("rst_mid_reads", rd_count - r0, 0);

        // first accept on the first edge after release
        resetN = 1'b1;
        bus.cmdValid = 1'b1;
        bus.cmdPush  = 1'b1;
        bus.cmdData  = 16'hABCD;
        @(negedge clock); #2;
        bus.cmdValid = 1'b0;
        wait_done(err, lat);
        $display("txn push data=abcd (at reset release) err=%0d latency=%0d", err, lat);
        check("post_rst_latency", lat, 2);
        check("post_rst_addr",    last_wr_addr, 16'h0204);
        do_cmd(1'b0, 16'h0000, err, lat);
        check("post_rst_pop", bus.popData, 16'hABCD);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
